dino_motion_ctrl: RTL and testbench

DINO_MOTION_CTRL -- requirements
Module: dino_motion_ctrl

---
 rtl/dino_motion_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dino_motion_ctrl.sv
// Dino runner motion controller: frame-paced run/jump/duck/dead FSM with
// ballistic jump arc and run-cycle leg animation.
module dino_motion_ctrl #(
  parameter logic [7:0] GROUND_Y = 8'd200,
  parameter logic [5:0] JUMP_V0  = 6'd12,
  parameter logic [5:0] GRAVITY  = 6'd1,
  parameter logic [3:0] ANIM_DIV = 4'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       duck_btn,
  input  logic       collide,
  input  logic       restart,
  output logic [7:0] dino_y,
  output logic [1:0] pose,
  output logic [1:0] leg_phase,
  output logic       airborne,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_JUMP = 3'd2,
    ST_DUCK = 3'd3,
    ST_DEAD = 3'd4
  } state_e;

  localparam logic [7:0]        TAKEOFF_Y = GROUND_Y - 8'(JUMP_V0);
  localparam logic signed [5:0] TAKEOFF_V = $signed(6'(JUMP_V0 - GRAVITY));
  localparam logic signed [6:0] VEL_MIN   = -7'sd31;

  state_e            state_q, state_d;
  logic [7:0]        y_q, y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [1:0]        leg_q, leg_d;
  logic [3:0]        anim_q, anim_d;
  logic              pend_q, pend_d;
  logic              hit_q, hit_d;
  logic              jbtn_q, jbtn_d;
  logic [1:0]        pose_q, pose_d;
  logic              air_q, air_d;
  logic              go_q, go_d;

  logic              jump_rise;
  logic              pend_now;
  logic              hit_now;
  logic signed [9:0] y_next;
  logic signed [9:0] ground_s;
  logic signed [6:0] vel_dec;
  logic signed [5:0] vel_sat;

  assign jump_rise = jump_btn & ~jbtn_q;
  assign pend_now  = pend_q | jump_rise;
  assign hit_now   = hit_q | collide;
  assign ground_s  = $signed({2'b00, GROUND_Y});
  assign y_next    = $signed({2'b00, y_q}) - $signed({{4{vel_q[5]}}, vel_q});
  assign vel_dec   = $signed({vel_q[5], vel_q}) - $signed({1'b0, GRAVITY});
  assign vel_sat   = (vel_dec < VEL_MIN) ? -6'sd31 : vel_dec[5:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= GROUND_Y;
      vel_q   <= '0;
      leg_q   <= '0;
      anim_q  <= '0;
      pend_q  <= 1'b0;
      hit_q   <= 1'b0;
      jbtn_q  <= 1'b0;
      pose_q  <= 2'd0;
      air_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      leg_q   <= leg_d;
      anim_q  <= anim_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      jbtn_q  <= jbtn_d;
      pose_q  <= pose_d;
      air_q   <= air_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    leg_d   = leg_q;
    anim_d  = anim_q;
    pend_d  = pend_now;
    hit_d   = hit_now;
    jbtn_d  = jump_btn;

    if (restart) begin
      state_d = ST_IDLE;
      y_d     = GROUND_Y;
      vel_d   = '0;
      leg_d   = '0;
      anim_d  = '0;
      pend_d  = 1'b0;
      hit_d   = 1'b0;
    end else if (frame_tick) begin
      // Latched requests are consumed by every tick, used or not.
      pend_d = 1'b0;
      hit_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          y_d = GROUND_Y;
          if (pend_now) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (hit_now) begin
            state_d = ST_DEAD;
          end else if (pend_now) begin
            state_d = ST_JUMP;
            y_d     = TAKEOFF_Y;
            vel_d   = TAKEOFF_V;
          end else if (duck_btn) begin
            state_d = ST_DUCK;
          end else if (anim_q == ANIM_DIV - 4'd1) begin
            anim_d = '0;
            leg_d  = (leg_q == 2'd2) ? 2'd0 : leg_q + 2'd1;
          end else begin
            anim_d = anim_q + 4'd1;
          end
        end
        ST_JUMP: begin
          if (hit_now) begin
            state_d = ST_DEAD;
          end else if (y_next >= ground_s) begin
            state_d = ST_RUN;
            y_d     = GROUND_Y;
            vel_d   = '0;
          end else begin
            vel_d = vel_sat;
            y_d   = (y_next < 10'sd0) ? 8'd0 : y_next[7:0];
          end
        end
        ST_DUCK: begin
          if (hit_now) begin
            state_d = ST_DEAD;
          end else if (pend_now) begin
            state_d = ST_JUMP;
            y_d     = TAKEOFF_Y;
            vel_d   = TAKEOFF_V;
          end else if (!duck_btn) begin
            state_d = ST_RUN;
          end
        end
        ST_DEAD: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Sprite/status flags track the next state so they land with it.
    pose_d = 2'd0;
    air_d  = 1'b0;
    go_d   = 1'b0;
    case (state_d)
      ST_JUMP: begin pose_d = 2'd1; air_d = 1'b1; end
      ST_DUCK: pose_d = 2'd2;
      ST_DEAD: begin pose_d = 2'd3; go_d = 1'b1; end
      default: pose_d = 2'd0;
    endcase
  end

  assign dino_y    = y_q;
  assign pose      = pose_q;
  assign leg_phase = leg_q;
  assign airborne  = air_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Scoreboard bench for dino_motion_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares after every tick, restart or probe.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump_btn = 1'b0;
  logic       duck_btn = 1'b0;
  logic       collide = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] dino_y;
  logic [1:0] pose;
  logic [1:0] leg_phase;
  logic       airborne;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  bit tick_d    = 1'b0;
  bit restart_d = 1'b0;
  bit probe     = 1'b0;

  typedef struct {
    logic [7:0] y;
    logic [1:0] pose;
    logic [1:0] leg;
    logic       air;
    logic       go;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] arc [25] = '{8'd188, 8'd177, 8'd167, 8'd158, 8'd150, 8'd143, 8'd137,
                           8'd132, 8'd128, 8'd125, 8'd123, 8'd122, 8'd122, 8'd123,
                           8'd125, 8'd128, 8'd132, 8'd137, 8'd143, 8'd150, 8'd158,
                           8'd167, 8'd177, 8'd188, 8'd200};

  dino_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .jump_btn   (jump_btn),
    .duck_btn   (duck_btn),
    .collide    (collide),
    .restart    (restart),
    .dino_y     (dino_y),
    .pose       (pose),
    .leg_phase  (leg_phase),
    .airborne   (airborne),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_d    <= frame_tick;
    restart_d <= restart;
  end

  // Monitor: one expectation per DUT response event.
  always @(negedge clk) begin
    if (tick_d || restart_d || probe) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_response: got y=%0d pose=%0d leg=%0d, want no response queued",
                 dino_y, pose, leg_phase);
      end else begin
        e = exp_q.pop_front();
        if ({dino_y, pose, leg_phase, airborne, game_over} !==
            {e.y, e.pose, e.leg, e.air, e.go}) begin
          bad++;
          $display("FAIL %s: got y=%0d pose=%0d leg=%0d air=%0d go=%0d, want y=%0d pose=%0d leg=%0d air=%0d go=%0d",
                   e.name, dino_y, pose, leg_phase, airborne, game_over,
                   e.y, e.pose, e.leg, e.air, e.go);
        end
      end
    end
  end

  task automatic push(input logic [7:0] y, input logic [1:0] p, input logic [1:0] lg,
                      input logic a, input logic g, input string n);
    exp_t e;
    e.y = y; e.pose = p; e.leg = lg; e.air = a; e.go = g; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit jmp, input logic [7:0] y, input logic [1:0] p,
                      input logic [1:0] lg, input logic a, input logic g, input string n);
    @(posedge clk); #1;
    frame_tick = 1'b1;
    if (jmp) jump_btn = 1'b1;
    push(y, p, lg, a, g, n);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
  endtask

  task automatic probe_chk(input logic [7:0] y, input logic [1:0] p, input logic [1:0] lg,
                           input logic a, input logic g, input string n);
    push(y, p, lg, a, g, n);
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic jump_pulse();
    @(posedge clk); #1 jump_btn = 1'b1;
    @(posedge clk); #1 jump_btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 probe_chk(8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "reset_state");
    @(posedge clk); #1 reset = 1'b0;

    tick(1'b0, 8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "idle_hold");
    tick(1'b1, 8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "idle_to_run");

    for (int i = 1; i <= 18; i++)
      tick(1'b0, 8'd200, 2'd0, 2'((i / 6) % 3), 1'b0, 1'b0, "anim");

    // Full arc; extra jump edges on tick 7 and between ticks 9/10 must be ignored.
    for (int k = 1; k <= 25; k++) begin
      if (k == 10) jump_pulse();
      tick(k == 1 || k == 7, arc[k-1], (k == 25) ? 2'd0 : 2'd1, 2'd0,
           (k != 25), 1'b0, "jump_arc");
    end

    for (int i = 1; i <= 7; i++)
      tick(1'b0, 8'd200, 2'd0, (i >= 6) ? 2'd1 : 2'd0, 1'b0, 1'b0, "run_leg");

    duck_btn = 1'b1;
    tick(1'b0, 8'd200, 2'd2, 2'd1, 1'b0, 1'b0, "duck_on");
    duck_btn = 1'b0;
    tick(1'b0, 8'd200, 2'd0, 2'd1, 1'b0, 1'b0, "duck_off");
    duck_btn = 1'b1;
    tick(1'b1, 8'd188, 2'd1, 2'd1, 1'b1, 1'b0, "duck_jump");
    duck_btn = 1'b0;
    for (int k = 2; k <= 5; k++)
      tick(1'b0, arc[k-1], 2'd1, 2'd1, 1'b1, 1'b0, "jump2_arc");

    @(posedge clk); #1 collide = 1'b1;
    @(posedge clk); #1 collide = 1'b0;
    @(posedge clk);
    tick(1'b0, 8'd150, 2'd3, 2'd1, 1'b0, 1'b1, "collide_dead");

    for (int i = 0; i < 10; i++) begin
      duck_btn = i[0];
      collide  = i[1];
      tick(i[0], 8'd150, 2'd3, 2'd1, 1'b0, 1'b1, "dead_hold");
      collide  = 1'b0;
    end
    duck_btn = 1'b0;

    @(posedge clk); #1;
    restart    = 1'b1;
    frame_tick = 1'b1;
    push(8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "restart");
    @(posedge clk); #1;
    restart    = 1'b0;
    frame_tick = 1'b0;

    tick(1'b0, 8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "idle_after_restart");
    tick(1'b1, 8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "run_again");
    tick(1'b1, 8'd188, 2'd1, 2'd0, 1'b1, 1'b0, "takeoff_again");
    tick(1'b0, 8'd177, 2'd1, 2'd0, 1'b1, 1'b0, "air_again");

    @(posedge clk); #2 reset = 1'b1;
    probe_chk(8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "async_reset_midjump");
    @(posedge clk); #1 reset = 1'b0;
    tick(1'b0, 8'd200, 2'd0, 2'd0, 1'b0, 1'b0, "post_reset_idle");

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
